// File: rtl/image_pixel_streamer.sv
// Sequential reader for the image ROM: walks IMG_W x IMG_H words from BASE_ADDR
// in raster order and streams each pixel with its coordinates over valid/ready.
`timescale 1ns/1ps

module image_pixel_streamer #(
  parameter int          IMG_W     = 90,
  parameter int          IMG_H     = 90,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rd,
  output logic [31:0] pix_data,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        pix_eol,
  output logic        pix_last,
  output logic        pix_valid,
  input  logic        pix_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [13:0] LAST_IDX = 14'(IMG_W * IMG_H - 1);
  localparam logic [15:0] LAST_X   = 16'(IMG_W - 1);

  state_t      state, state_nxt;
  logic [13:0] idx;
  logic [15:0] x, y;
  logic        frame_start, load, xfer, kill;

  // abort outranks every other event once a frame is in flight.
  assign kill        = abort && (state != IDLE);
  assign frame_start = (state == IDLE) && start && !abort;
  assign load        = (state == RUN) && (!pix_valid || pix_ready) && !abort;
  assign xfer        = (state == DRAIN) && pix_valid && pix_ready && !abort;

  assign busy     = (state != IDLE);
  assign rom_addr = (state == RUN) ? BASE_ADDR + {18'd0, idx} : BASE_ADDR;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this purely combinational with no
  // inferred latch on paths that do not change state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (load && idx == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (abort || xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      x         <= '0;
      y         <= '0;
      done      <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_eol   <= 1'b0;
      pix_last  <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      done <= xfer;
      if (frame_start) begin
        idx <= '0;
        x   <= '0;
        y   <= '0;
      end
      if (kill) begin
        pix_valid <= 1'b0;
      end else if (load) begin
        pix_data  <= rom_rd;
        pix_x     <= x;
        pix_y     <= y;
        pix_eol   <= (x == LAST_X);
        pix_last  <= (idx == LAST_IDX);
        pix_valid <= 1'b1;
        idx       <= idx + 14'd1;
        if (x == LAST_X) begin
          x <= '0;
          y <= y + 16'd1;
        end else begin
          x <= x + 16'd1;
        end
      end else if (xfer) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Scoreboard bench: three streamer instances (90x90 @0, 3x2 @100, 1x1 @5), each
// reading a ROM model whose word is addr ^ 32'hA5A5_0000.
`timescale 1ns/1ps

module tb_image_pixel_streamer;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] x;
    logic [15:0] y;
    logic        eol;
    logic        last;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start = '0, abort = '0, ready = '0;
  logic [2:0]  busy, done, pix_eol, pix_last, pix_valid;
  logic [31:0] rom_addr [3];
  logic [31:0] rom_rd   [3];
  logic [31:0] pix_data [3];
  logic [15:0] pix_x    [3];
  logic [15:0] pix_y    [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    image_pixel_streamer #(
      .IMG_W    (g == 0 ? 90 : (g == 1 ? 3 : 1)),
      .IMG_H    (g == 0 ? 90 : (g == 1 ? 2 : 1)),
      .BASE_ADDR(g == 0 ? 32'd0 : (g == 1 ? 32'd100 : 32'd5))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .abort    (abort[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .rom_addr (rom_addr[g]),
      .rom_rd   (rom_rd[g]),
      .pix_data (pix_data[g]),
      .pix_x    (pix_x[g]),
      .pix_y    (pix_y[g]),
      .pix_eol  (pix_eol[g]),
      .pix_last (pix_last[g]),
      .pix_valid(pix_valid[g]),
      .pix_ready(ready[g])
    );
    assign rom_rd[g] = rom_addr[g] ^ 32'hA5A5_0000;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  pix_t q [3][$];
  int   xfer_cnt [3] = '{0, 0, 0};
  int   done_cnt [3] = '{0, 0, 0};
  bit   exp_done [3] = '{0, 0, 0};
  bit   prev_stall [3] = '{0, 0, 0};
  bit   prev_abort [3] = '{0, 0, 0};
  pix_t prev_out [3];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Monitor: compares every transfer against the scoreboard, checks stall
  // stability and the done pulse timing.
  always @(negedge clk) begin
    pix_t cur, exp_p;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        cur = '{pix_data[k], pix_x[k], pix_y[k], pix_eol[k], pix_last[k]};
        if (prev_stall[k] && !prev_abort[k]) begin
          check("stall_valid", pix_valid[k], 1'b1);
          check("stall_hold", cur, prev_out[k]);
        end
        if (done[k] || exp_done[k]) begin
          check("done_pulse", done[k], exp_done[k]);
          if (done[k]) begin
            done_cnt[k]++;
            check("busy_at_done", busy[k], 1'b0);
          end
        end
        exp_done[k] = 1'b0;
        if (pix_valid[k] && ready[k] && !abort[k]) begin
          xfer_cnt[k]++;
          check("queue_nonempty", q[k].size() != 0, 1'b1);
          if (q[k].size() != 0) begin
            exp_p = q[k].pop_front();
            check("pixel", cur, exp_p);
            if (exp_p.last) exp_done[k] = 1'b1;
          end
        end
        prev_stall[k] = pix_valid[k] && !ready[k];
        prev_out[k]   = cur;
        prev_abort[k] = abort[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int k, input int w, input int h, input int base);
    pix_t p;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        p.data = 32'(base + yy * w + xx) ^ 32'hA5A5_0000;
        p.x    = 16'(xx);
        p.y    = 16'(yy);
        p.eol  = (xx == w - 1);
        p.last = (yy * w + xx == w * h - 1);
        q[k].push_back(p);
      end
    end
  endtask

  task automatic start_frame(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    check("busy_after_start", busy[k], 1'b1);
    check("valid_before_load", pix_valid[k], 1'b0);
    tick();
    check("first_valid", pix_valid[k], 1'b1);
  endtask

  task automatic do_frame(input int k, input int w, input int h, input int base,
                          input bit rnd, input bit mid_start);
    int d0, x0, c;
    d0 = done_cnt[k];
    x0 = xfer_cnt[k];
    push_frame(k, w, h, base);
    ready[k] = 1'b1;
    start_frame(k);
    c = 0;
    while (done_cnt[k] == d0 && c < 40000) begin
      if (rnd) ready[k] = 1'($urandom_range(0, 1));
      start[k] = mid_start && (c == 500);
      tick();
      c++;
    end
    start[k] = 1'b0;
    ready[k] = 1'b1;
    repeat (4) tick();
    check("frame_done_count", done_cnt[k] - d0, 1);
    check("frame_pixels", xfer_cnt[k] - x0, w * h);
    check("queue_drained", q[k].size(), 0);
    check("idle_after_frame", busy[k], 1'b0);
  endtask

  initial begin
    int x0, d0, c;
    // T1: reset with random inputs
    repeat (5) begin
      start = 3'($urandom);
      abort = 3'($urandom);
      ready = 3'($urandom);
      tick();
    end
    check("rst_valid", pix_valid, 3'b000);
    check("rst_busy", busy, 3'b000);
    check("rst_done", done, 3'b000);
    check("rst_addr0", rom_addr[0], 32'd0);
    check("rst_addr1", rom_addr[1], 32'd100);
    check("rst_addr2", rom_addr[2], 32'd5);
    start = '0;
    abort = '0;
    ready = '0;
    rst_n = 1'b1;
    repeat (2) tick();

    // T2: full frame, ready held high
    do_frame(0, 90, 90, 0, 1'b0, 1'b0);

    // T3: pseudo-random backpressure
    do_frame(0, 90, 90, 0, 1'b1, 1'b0);

    // T4: abort while stalled on pixel 1234
    d0 = done_cnt[0];
    x0 = xfer_cnt[0];
    push_frame(0, 90, 90, 0);
    ready[0] = 1'b1;
    start_frame(0);
    c = 0;
    while (xfer_cnt[0] - x0 < 1234 && c < 5000) begin
      tick();
      c++;
    end
    ready[0] = 1'b0;
    repeat (3) tick();
    check("stall_pixel_valid", pix_valid[0], 1'b1);
    check("stall_pixel_x", pix_x[0], 16'd64);
    check("stall_pixel_y", pix_y[0], 16'd13);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_valid", pix_valid[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    repeat (5) tick();
    check("abort_no_done", done_cnt[0] - d0, 0);
    q[0].delete();

    // T5: start with abort in IDLE is ignored
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("start_abort_idle_busy", busy[0], 1'b0);
    tick();
    check("start_abort_idle_valid", pix_valid[0], 1'b0);

    // T4/T5: restart from (0,0) with a stray start mid-frame
    do_frame(0, 90, 90, 0, 1'b0, 1'b1);

    // T6: small images
    do_frame(1, 3, 2, 100, 1'b1, 1'b0);
    do_frame(1, 3, 2, 100, 1'b0, 1'b0);
    do_frame(2, 1, 1, 5, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
